// File: rtl/decode_stage.sv
// Registered instruction-decode stage with zf interlock, branch-shadow kill and flush.
// Optional: define DECODE_ILLEGAL_TRAP_EN to redirect unknown opcodes to TRAP_VEC.
module decode_stage #(
  parameter int OP_W     = 16,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 4,
  parameter int PC_W     = 8,
  parameter int DATA_W   = 40,
  parameter int ZF_LAT   = 2,
  parameter int SHADOW   = 1,
  parameter int TRAP_VEC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic              zf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_in,
  output logic              pc_we,
  output logic [REG_AW-1:0] src0,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] dst,
  output logic              reg_we,
  output logic              sel1,
  output logic              sel2,
  output logic [DATA_W-1:0] data,
  output logic [OPC_W-1:0]  alu_op,
  output logic              mem_we,
  output logic              illegal
);

  localparam logic [OPC_W-1:0] JMP        = OPC_W'(0);
  localparam logic [OPC_W-1:0] JNZ        = OPC_W'(1);
  localparam logic [OPC_W-1:0] INC        = OPC_W'(2);
  localparam logic [OPC_W-1:0] INC_DEPTH  = OPC_W'(3);
  localparam logic [OPC_W-1:0] COPY       = OPC_W'(4);
  localparam logic [OPC_W-1:0] REFERENCE  = OPC_W'(5);
  localparam logic [OPC_W-1:0] TO_UP      = OPC_W'(6);
  localparam logic [OPC_W-1:0] TO_DOWN    = OPC_W'(7);
  localparam logic [OPC_W-1:0] TO_LEFT    = OPC_W'(8);
  localparam logic [OPC_W-1:0] TO_RIGHT   = OPC_W'(9);
  localparam logic [OPC_W-1:0] INIT_DEPTH = OPC_W'(10);
  localparam logic [OPC_W-1:0] WHERE_ZERO = OPC_W'(11);
  localparam logic [OPC_W-1:0] COMP       = OPC_W'(12);
  localparam logic [OPC_W-1:0] CHECK      = OPC_W'(13);
  localparam logic [OPC_W-1:0] CHECK_4    = OPC_W'(14);
  localparam logic [OPC_W-1:0] POS_UP     = OPC_W'(15);
  localparam logic [OPC_W-1:0] POS_DOWN   = OPC_W'(16);
  localparam logic [OPC_W-1:0] POS_LEFT   = OPC_W'(17);
  localparam logic [OPC_W-1:0] POS_RIGHT  = OPC_W'(18);
  localparam logic [OPC_W-1:0] STORE      = OPC_W'(19);
  localparam logic [OPC_W-1:0] LI         = OPC_W'(20);

  // RA/RB: top bits of the first and second register fields below the opcode
  localparam int RA = OP_W - OPC_W - 1;
  localparam int RB = RA - REG_AW;
  localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  logic [OPC_W-1:0]  opc;
  logic [PC_W-1:0]   pc_in_p0;
  logic              pc_we_p0, reg_we_p0, sel1_p0, sel2_p0, mem_we_p0;
  logic [REG_AW-1:0] src0_p0, src1_p0, dst_p0;
  logic [DATA_W-1:0] data_p0;
  logic              is_flag_p0, is_cons_p0, bad_p0;

  assign opc = op[OP_W-1 -: OPC_W];

  // Stage p0: combinational decode, every field defaulted
  always_comb begin
    pc_in_p0   = '0;
    pc_we_p0   = 1'b0;
    src0_p0    = '0;
    src1_p0    = '0;
    dst_p0     = '0;
    reg_we_p0  = 1'b0;
    sel1_p0    = 1'b0;
    sel2_p0    = 1'b0;
    data_p0    = '0;
    mem_we_p0  = 1'b0;
    is_flag_p0 = 1'b0;
    bad_p0     = 1'b0;
    case (opc)
      JMP: begin
        pc_we_p0 = 1'b1;
        pc_in_p0 = op[PC_W-1:0];
      end
      JNZ: begin
        pc_we_p0 = zf;
        pc_in_p0 = op[PC_W-1:0];
      end
      INC, INC_DEPTH: begin
        dst_p0    = op[RA -: REG_AW];
        src1_p0   = op[RB -: REG_AW];
        reg_we_p0 = 1'b1;
      end
      COPY, REFERENCE, TO_UP, TO_DOWN, TO_LEFT, TO_RIGHT, INIT_DEPTH: begin
        dst_p0    = op[RA -: REG_AW];
        src1_p0   = op[RB -: REG_AW];
        reg_we_p0 = 1'b1;
        sel1_p0   = 1'b1;
      end
      WHERE_ZERO: begin
        dst_p0    = op[RA -: REG_AW];
        src1_p0   = op[RB -: REG_AW];
        reg_we_p0 = 1'b1;
        sel2_p0   = 1'b1;
      end
      COMP: begin
        src1_p0    = op[2*REG_AW-1 -: REG_AW];
        src0_p0    = op[REG_AW-1:0];
        sel1_p0    = 1'b1;
        pc_we_p0   = zf;
        is_flag_p0 = 1'b1;
      end
      CHECK: begin
        src1_p0    = op[REG_AW+1 -: REG_AW];
        data_p0    = DATA_W'(op[1:0]);
        pc_we_p0   = zf;
        is_flag_p0 = 1'b1;
      end
      CHECK_4: begin
        src1_p0                 = op[RA -: REG_AW];
        data_p0[DATA_W-1 -: 4]  = op[RB -: 4];
        pc_we_p0                = zf;
        is_flag_p0              = 1'b1;
      end
      POS_UP, POS_DOWN, POS_LEFT, POS_RIGHT: begin
        src0_p0    = op[REG_AW-1:0];
        sel1_p0    = 1'b1;
        pc_we_p0   = zf;
        is_flag_p0 = 1'b1;
      end
      STORE: begin
        src1_p0   = op[RA -: REG_AW];
        src0_p0   = op[RB -: REG_AW];
        sel1_p0   = 1'b1;
        mem_we_p0 = 1'b1;
      end
      LI: begin
        dst_p0    = op[RA -: REG_AW];
        data_p0   = DATA_W'(op[RB:0]);
        reg_we_p0 = 1'b1;
        sel1_p0   = 1'b1;
      end
      default: begin
        bad_p0   = 1'b1;
        pc_we_p0 = TRAP_EN;
        pc_in_p0 = TRAP_EN ? TRAP_PC : '0;
      end
    endcase
  end

  assign is_cons_p0 = is_flag_p0 || (opc == JNZ);

  logic              vld_p1, illegal_p1;
  logic [2:0]        zcnt_p1, scnt_p1;
  logic [PC_W-1:0]   pc_in_p1;
  logic              pc_we_p1, reg_we_p1, sel1_p1, sel2_p1, mem_we_p1;
  logic [REG_AW-1:0] src0_p1, src1_p1, dst_p1;
  logic [DATA_W-1:0] data_p1;
  logic [OPC_W-1:0]  alu_op_p1;
  logic              zf_wait_ok, accept, drop, take;

  // Only zf consumers wait on a pending flag; everything else flows through
  assign zf_wait_ok = !((zcnt_p1 != 3'd0) && in_valid && is_cons_p0);
  assign in_ready   = (!vld_p1 || out_ready) && zf_wait_ok && !flush;
  assign accept     = in_valid && in_ready;
  assign drop       = accept && (scnt_p1 != 3'd0);
  assign take       = accept && (scnt_p1 == 3'd0);

  // Stage p1: output register and interlock counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      zcnt_p1    <= 3'd0;
      scnt_p1    <= 3'd0;
      pc_in_p1   <= '0;
      pc_we_p1   <= 1'b0;
      src0_p1    <= '0;
      src1_p1    <= '0;
      dst_p1     <= '0;
      reg_we_p1  <= 1'b0;
      sel1_p1    <= 1'b0;
      sel2_p1    <= 1'b0;
      data_p1    <= '0;
      alu_op_p1  <= '0;
      mem_we_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      zcnt_p1 <= 3'd0;
      scnt_p1 <= 3'd0;
    end else begin
      vld_p1 <= take || (vld_p1 && !out_ready);
      if (take) begin
        pc_in_p1  <= pc_in_p0;
        pc_we_p1  <= pc_we_p0;
        src0_p1   <= src0_p0;
        src1_p1   <= src1_p0;
        dst_p1    <= dst_p0;
        reg_we_p1 <= reg_we_p0;
        sel1_p1   <= sel1_p0;
        sel2_p1   <= sel2_p0;
        data_p1   <= data_p0;
        alu_op_p1 <= opc;
        mem_we_p1 <= mem_we_p0;
      end
      if (take && bad_p0)
        illegal_p1 <= 1'b1;
      if (take && is_flag_p0)
        zcnt_p1 <= 3'(ZF_LAT);
      else
        zcnt_p1 <= sat_dec(zcnt_p1);
      if (take && pc_we_p0)
        scnt_p1 <= 3'(SHADOW);
      else if (drop)
        scnt_p1 <= sat_dec(scnt_p1);
    end
  end

  assign out_valid = vld_p1;
  assign illegal   = illegal_p1;
  assign pc_in     = pc_in_p1;
  assign pc_we     = pc_we_p1;
  assign src0      = src0_p1;
  assign src1      = src1_p1;
  assign dst       = dst_p1;
  assign reg_we    = reg_we_p1;
  assign sel1      = sel1_p1;
  assign sel2      = sel2_p1;
  assign data      = data_p1;
  assign alu_op    = alu_op_p1;
  assign mem_we    = mem_we_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// against a timestamp-based behavioural model (default parameters).
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, zf, flush, out_valid, out_ready;
  logic        pc_we, reg_we, sel1, sel2, mem_we, illegal;
  logic [15:0] op;
  logic [7:0]  pc_in;
  logic [3:0]  src0, src1, dst;
  logic [39:0] data;
  logic [4:0]  alu_op;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] C_JMP = 5'd0, C_JNZ = 5'd1, C_INC = 5'd2, C_INCD = 5'd3;
  localparam logic [4:0] C_COPY = 5'd4, C_REF = 5'd5, C_TUP = 5'd6, C_TDN = 5'd7;
  localparam logic [4:0] C_TLF = 5'd8, C_TRT = 5'd9, C_INIT = 5'd10, C_WZ = 5'd11;
  localparam logic [4:0] C_COMP = 5'd12, C_CHK = 5'd13, C_CHK4 = 5'd14;
  localparam logic [4:0] C_PUP = 5'd15, C_PDN = 5'd16, C_PLF = 5'd17, C_PRT = 5'd18;
  localparam logic [4:0] C_STORE = 5'd19, C_LI = 5'd20;
  localparam int LAT = 2;
  localparam int SHD = 1;

  typedef struct packed {
    logic [7:0]  pc_in;
    logic        pc_we;
    logic [3:0]  src0, src1, dst;
    logic        reg_we, sel1, sel2;
    logic [39:0] data;
    logic [4:0]  alu_op;
    logic        mem_we;
  } bundle_t;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .zf(zf),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .pc_in(pc_in),
    .pc_we(pc_we), .src0(src0), .src1(src1), .dst(dst), .reg_we(reg_we), .sel1(sel1),
    .sel2(sel2), .data(data), .alu_op(alu_op), .mem_we(mem_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [4:0] c, input logic [10:0] f);
    return {c, f};
  endfunction

  function automatic bundle_t observed();
    return '{pc_in, pc_we, src0, src1, dst, reg_we, sel1, sel2, data, alu_op, mem_we};
  endfunction

  function automatic bit is_flag(input logic [4:0] c);
    return (c == C_COMP) || (c == C_CHK) || (c == C_CHK4) ||
           (c == C_PUP) || (c == C_PDN) || (c == C_PLF) || (c == C_PRT);
  endfunction

  function automatic bit is_bad(input logic [4:0] c);
    return c > C_LI;
  endfunction

  // Reference decode straight from the opcode table, default field positions
  function automatic bundle_t ref_decode(input logic [15:0] o, input logic z);
    bundle_t b;
    logic [4:0] c;
    b = '0;
    c = o[15:11];
    b.alu_op = c;
    if (c == C_JMP) begin b.pc_we = 1'b1; b.pc_in = o[7:0]; end
    else if (c == C_JNZ) begin b.pc_we = z; b.pc_in = o[7:0]; end
    else if (c inside {C_INC, C_INCD, C_COPY, C_REF, C_TUP, C_TDN, C_TLF, C_TRT, C_INIT, C_WZ}) begin
      b.dst = o[10:7]; b.src1 = o[6:3]; b.reg_we = 1'b1;
      b.sel1 = c inside {C_COPY, C_REF, C_TUP, C_TDN, C_TLF, C_TRT, C_INIT};
      b.sel2 = (c == C_WZ);
    end
    else if (c == C_COMP) begin b.src1 = o[7:4]; b.src0 = o[3:0]; b.sel1 = 1'b1; b.pc_we = z; end
    else if (c == C_CHK) begin b.src1 = o[5:2]; b.data = {38'd0, o[1:0]}; b.pc_we = z; end
    else if (c == C_CHK4) begin b.src1 = o[10:7]; b.data = {o[6:3], 36'd0}; b.pc_we = z; end
    else if (c inside {C_PUP, C_PDN, C_PLF, C_PRT}) begin b.src0 = o[3:0]; b.sel1 = 1'b1; b.pc_we = z; end
    else if (c == C_STORE) begin b.src1 = o[10:7]; b.src0 = o[6:3]; b.sel1 = 1'b1; b.mem_we = 1'b1; end
    else if (c == C_LI) begin b.dst = o[10:7]; b.data = {33'd0, o[6:0]}; b.reg_we = 1'b1; b.sel1 = 1'b1; end
    else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      b.pc_we = 1'b1;
      b.pc_in = 8'd0;
`endif
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; zf = 1'b0; op = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (observed() !== '0) begin errors++; $display("FAIL reset_bundle: got %h want 0", observed()); end
    op = mk(C_LI, {4'd7, 7'h11}); in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || observed() !== '0) begin
      errors++; $display("FAIL midop_reset: valid %b bundle %h want 0/0", out_valid, observed()); end
  endtask

  task automatic test_jmp_shadow();
    out_ready = 1'b1; zf = 1'b0;
    op = mk(C_JMP, 11'h02A); in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jmp_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || pc_we !== 1'b1 || pc_in !== 8'h2A) begin
      errors++; $display("FAIL jmp_bundle: valid %b pc_we %b pc_in %h want 1 1 2a", out_valid, pc_we, pc_in); end
    op = mk(C_INC, {4'd1, 4'd2, 3'd0});
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL shadow_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL shadow_drop: got valid %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || dst !== 4'd1 || src1 !== 4'd2 || reg_we !== 1'b1) begin
      errors++; $display("FAIL after_shadow: valid %b dst %0d src1 %0d we %b want 1 1 2 1", out_valid, dst, src1, reg_we); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_hold();
    bundle_t li_b;
    out_ready = 1'b0; zf = 1'b0;
    op = mk(C_LI, {4'd3, 7'h55}); in_valid = 1'b1;
    li_b = ref_decode(op, zf);
    tick();
    checks++; if (dst !== 4'd3 || data !== 40'h55 || reg_we !== 1'b1 || sel1 !== 1'b1) begin
      errors++; $display("FAIL li_fields: dst %0d data %h we %b sel1 %b want 3 55 1 1", dst, data, reg_we, sel1); end
    op = mk(C_STORE, {4'd2, 4'd5, 3'd0});
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || observed() !== li_b) begin
        errors++; $display("FAIL hold_stable[%0d]: got %h want %h", i, observed(), li_b); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || mem_we !== 1'b1 || src1 !== 4'd2 || src0 !== 4'd5 || reg_we !== 1'b0) begin
      errors++; $display("FAIL store_fields: mem_we %b src1 %0d src0 %0d reg_we %b want 1 2 5 0", mem_we, src1, src0, reg_we); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL store_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_interlock();
    out_ready = 1'b1; zf = 1'b0;
    op = mk(C_COMP, {3'd0, 4'd1, 4'd4}); in_valid = 1'b1;
    tick();
    checks++; if (src1 !== 4'd1 || src0 !== 4'd4 || sel1 !== 1'b1 || pc_we !== 1'b0) begin
      errors++; $display("FAIL comp_fields: src1 %0d src0 %0d sel1 %b pc_we %b want 1 4 1 0", src1, src0, sel1, pc_we); end
    op = mk(C_JNZ, 11'h033); zf = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL jnz_stall[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    zf = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL jnz_release: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_op !== C_JNZ || pc_we !== 1'b0 || pc_in !== 8'h33) begin
      errors++; $display("FAIL jnz_bundle: valid %b op %0d pc_we %b pc_in %h want 1 1 0 33", out_valid, alu_op, pc_we, pc_in); end
    op = mk(C_COMP, {3'd0, 4'd2, 4'd3});
    tick();
    op = mk(C_INC, {4'd4, 4'd5, 3'd0});
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inc_nostall: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_op !== C_INC || dst !== 4'd4) begin
      errors++; $display("FAIL inc_bundle: valid %b op %0d dst %0d want 1 2 4", out_valid, alu_op, dst); end
    idle(4);
  endtask

  task automatic test_check4();
    out_ready = 1'b1; zf = 1'b0;
    op = mk(C_CHK4, {4'd6, 4'hB, 3'd0}); in_valid = 1'b1;
    tick();
    checks++; if (src1 !== 4'd6 || data !== 40'hB0_0000_0000 || reg_we !== 1'b0 || pc_we !== 1'b0) begin
      errors++; $display("FAIL check4: src1 %0d data %h reg_we %b pc_we %b want 6 b000000000 0 0", src1, data, reg_we, pc_we); end
    idle(4);
  endtask

  task automatic test_illegal();
    bundle_t exp_b;
    out_ready = 1'b1; zf = 1'b0;
    op = mk(5'h1F, 11'h5A5); in_valid = 1'b1;
    exp_b = ref_decode(op, zf);
    tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", illegal); end
    checks++; if (out_valid !== 1'b1 || observed() !== exp_b) begin
      errors++; $display("FAIL illegal_bundle: got %h want %h", observed(), exp_b); end
    op = mk(C_LI, {4'd1, 7'h01});
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", illegal); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; zf = 1'b1;
    op = mk(C_COMP, {3'd0, 4'd3, 4'd2}); in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || pc_we !== 1'b1) begin
      errors++; $display("FAIL flush_setup: valid %b pc_we %b want 1 1", out_valid, pc_we); end
    flush = 1'b1; zf = 1'b0; op = mk(C_JNZ, 11'h044);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_op !== C_JNZ || pc_in !== 8'h44) begin
      errors++; $display("FAIL post_flush_jnz: valid %b op %0d pc_in %h want 1 1 44", out_valid, alu_op, pc_in); end
    idle(4);
  endtask

  // Model: zf consumers may issue from cycle zf_free_at; shadow_left ops get dropped
  task automatic test_random();
    bit      m_vld, m_ill, exp_ready, acc;
    bundle_t m_b;
    int      cyc, zf_free_at, shadow_left;
    logic [4:0] c;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    m_vld = 1'b0; m_ill = 1'b0; m_b = '0; cyc = 0; zf_free_at = 0; shadow_left = 0;
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      zf        = $urandom_range(1);
      flush     = ($urandom_range(24) == 0);
      op        = 16'($urandom);
      c         = op[15:11];
      exp_ready = (!m_vld || out_ready) && !flush &&
                  !(in_valid && (is_flag(c) || c == C_JNZ) && cyc < zf_free_at);
      #1;
      checks++; if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready); end
      acc = in_valid && exp_ready;
      if (flush) begin
        m_vld = 1'b0; zf_free_at = 0; shadow_left = 0;
      end else if (acc && shadow_left > 0) begin
        shadow_left--;
        m_vld = 1'b0;
      end else if (acc) begin
        m_b = ref_decode(op, zf);
        m_vld = 1'b1;
        if (is_flag(c)) zf_free_at = cyc + LAT + 1;
        if (m_b.pc_we) shadow_left = SHD;
        if (is_bad(c)) m_ill = 1'b1;
      end else begin
        m_vld = m_vld && !out_ready;
      end
      tick();
      cyc++;
      if (zf_free_at != 0 && flush) zf_free_at = 0;
      checks++; if (out_valid !== m_vld) begin
        errors++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, out_valid, m_vld); end
      if (m_vld) begin
        checks++; if (observed() !== m_b) begin
          errors++; $display("FAIL rnd_bundle cyc %0d: got %h want %h", cyc, observed(), m_b); end
      end
      checks++; if (illegal !== m_ill) begin
        errors++; $display("FAIL rnd_illegal cyc %0d: got %b want %b", cyc, illegal, m_ill); end
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; zf = 1'b0; op = '0;
    test_reset();
    test_jmp_shadow();
    test_hold();
    test_interlock();
    test_check4();
    test_illegal();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
